// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizes for the register-file access controller.
package rf_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FORCE = 2'd2
  } state_t;

endpackage

// File: rtl/rf_init_sweep.sv
// Post-reset sweep: walks every register index once, producing the init value for each.
module rf_init_sweep
  import rf_ctrl_pkg::*;
#(
  parameter int                INIT_REG = 9,
  parameter logic [DATA_W-1:0] INIT_VAL = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] val,
  output logic              last,
  output logic              done
);

  assign last = (idx == ADDR_W'(NUM_REGS - 1));
  assign val  = (idx == ADDR_W'(INIT_REG)) ? INIT_VAL : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      done <= 1'b0;
    end else if (en) begin
      idx <= idx + 1'b1;
      if (last) done <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file write port / read port 1 owner: init sweep, core passthrough, debug sharing.
//   state | meaning
//   INIT  | sweeping all registers after reset, core stalled
//   IDLE  | core owns ports; debug granted when the port it needs is free
//   FORCE | one-cycle core stall so a starved debug access can run
module regfile_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int                MAX_WAIT = 8,
  parameter int                CNT_W    = 4,
  parameter int                INIT_REG = 9,
  parameter logic [DATA_W-1:0] INIT_VAL = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_a3,
  input  logic [DATA_W-1:0] core_wd3,
  input  logic [ADDR_W-1:0] core_a1,
  input  logic              core_halt,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [DATA_W-1:0] rf_rd1,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic [ADDR_W-1:0] rf_a1,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              core_stall,
  output logic              init_done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               we_raw;
  logic               rd_gnt;
  logic [ADDR_W-1:0]  sweep_idx;
  logic [DATA_W-1:0]  sweep_val;
  logic               sweep_last;

  rf_init_sweep #(
    .INIT_REG (INIT_REG),
    .INIT_VAL (INIT_VAL)
  ) u_sweep (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == INIT),
    .idx  (sweep_idx),
    .val  (sweep_val),
    .last (sweep_last),
    .done (init_done)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    we_raw     = 1'b0;
    rf_a3      = core_a3;
    rf_wd3     = core_wd3;
    rf_a1      = core_a1;
    dbg_gnt    = 1'b0;
    rd_gnt     = 1'b0;
    core_stall = 1'b1;
    case (state_q)
      INIT: begin
        we_raw = 1'b1;
        rf_a3  = sweep_idx;
        rf_wd3 = sweep_val;
        if (sweep_last) state_d = IDLE;
      end
      IDLE: begin
        core_stall = 1'b0;
        we_raw     = core_we;
        wait_d     = '0;
        if (dbg_req) begin
          if (dbg_we && (!core_we || core_halt)) begin
            we_raw  = 1'b1;
            rf_a3   = dbg_addr;
            rf_wd3  = dbg_wdata;
            dbg_gnt = 1'b1;
          end else if (!dbg_we && core_halt) begin
            rf_a1   = dbg_addr;
            dbg_gnt = 1'b1;
            rd_gnt  = 1'b1;
          end else begin
            // count the blocked cycle; the MAX_WAIT-th one triggers the stall
            wait_d = wait_q + 1'b1;
            if (wait_d == CNT_W'(MAX_WAIT)) state_d = FORCE;
          end
        end
      end
      FORCE: begin
        wait_d  = '0;
        state_d = IDLE;
        if (dbg_req) begin
          dbg_gnt = 1'b1;
          if (dbg_we) begin
            we_raw = 1'b1;
            rf_a3  = dbg_addr;
            rf_wd3 = dbg_wdata;
          end else begin
            rf_a1  = dbg_addr;
            rd_gnt = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // x0 is hardwired zero; reset also blocks any write
  assign rf_we3 = we_raw && (rf_a3 != '0) && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      wait_q     <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      dbg_rvalid <= rd_gnt;
      if (rd_gnt) dbg_rdata <= rf_rd1;
    end
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Owns the register file's write port and read port 1.
- After reset, sweeps all 32 registers to known values while stalling the core.
- Then passes core writeback through and shares both ports with a debug requester.
- A wait counter prevents debug starvation by forcing a one-cycle core stall.

Parameters:
- MAX_WAIT, 8, cycles a debug request may be blocked before a forced stall (legal range 1..2^CNT_W-1).
- CNT_W, 4, width of the wait counter.
- INIT_REG, 9, register index loaded with INIT_VAL during the sweep.
- INIT_VAL, 32'h00000020, sweep value for INIT_REG; every other register gets 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- core_we  in  1  core writeback enable
- core_a3  in  5  core writeback address
- core_wd3  in  32  core writeback data
- core_a1  in  5  core read-port-1 address
- core_halt  in  1  core halted; read port 1 is free
- dbg_req  in  1  debug access request; held stable until dbg_gnt
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  5  debug register index
- dbg_wdata  in  32  debug write data
- rf_rd1  in  32  register file read data 1
- rf_we3  out  1  register file write enable
- rf_a3  out  5  register file write address
- rf_wd3  out  32  register file write data
- rf_a1  out  5  register file read address 1
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata valid
- dbg_rdata  out  32  captured read data
- core_stall  out  1  core must not advance PC or commit writeback
- init_done  out  1  sweep complete

Behaviour:
- Reset (rst low) values:
  - state=INIT, idx=0, wait_cnt=0.
  - init_done=0, core_stall=1, dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0.
  - rf_we3 is combinationally forced to 0 while rst is low.
- Port muxes are combinational; the core sees same-cycle writeback, as a single-cycle core requires.
- States: INIT, IDLE, FORCE.
- INIT:
  - Each cycle: rf_we3=1, rf_a3=idx, rf_wd3 = (idx==INIT_REG) ? INIT_VAL : 0.
  - idx increments each cycle. After idx=31 -> IDLE, so the sweep takes 32 cycles.
  - core_stall=1 throughout. dbg_gnt=0 and debug requests are ignored. core_halt is ignored.
  - init_done rises on the first IDLE cycle and stays 1 until reset.
- x0 guard: rf_we3 is masked to 0 whenever rf_a3==0, in all states.
- IDLE, default:
  - rf_we3/rf_a3/rf_wd3 = core_we/core_a3/core_wd3.
  - rf_a1=core_a1, core_stall=0.
- IDLE, debug write (dbg_req & dbg_we):
  - Granted if core_we==0 or core_halt==1.
  - On grant: rf_we3=1, rf_a3=dbg_addr, rf_wd3=dbg_wdata, dbg_gnt=1 in the same cycle.
- IDLE, debug read (dbg_req & ~dbg_we):
  - Granted only if core_halt==1.
  - On grant: rf_a1=dbg_addr, dbg_gnt=1.
  - rf_rd1 is captured into dbg_rdata at that edge. dbg_rvalid=1 the next cycle, for exactly one cycle.
- Blocked request: wait_cnt increments each cycle.
  - Cleared on grant or when dbg_req drops.
  - When wait_cnt==MAX_WAIT, the next state is FORCE.
- FORCE (exactly one cycle):
  - core_stall=1; the core write is suppressed and the core must re-present it next cycle.
  - The debug access executes unconditionally as in IDLE, with dbg_gnt=1.
  - Then return to IDLE with wait_cnt=0.
- Simultaneous core write and debug write to the same address: the core wins unless in FORCE.
- dbg_req dropping before grant: no access is performed and no rvalid is produced.
- Reset mid-INIT or mid-FORCE: returns immediately to INIT with idx=0; the sweep restarts in full.
- Back-to-back grants are allowed; at most one debug access per cycle.

Decomposition:
- Package rf_ctrl_pkg holds:
  - state enum {INIT, IDLE, FORCE}
  - NUM_REGS=32, ADDR_W=5, DATA_W=32
- Sub-module rf_init_sweep contains:
  - the idx counter
  - the done flag
  - INIT_REG/INIT_VAL value selection
- The top level holds the arbiter FSM, wait counter and port muxes.

Test Plan:
- Release rst, hold core idle:
  - 32 cycles of rf_we3 with idx 0..31; rf_a3=9 carries rf_wd3=0x20.
  - init_done=1 and core_stall=0 at cycle 32.
- IDLE, core_we=1, core_a3=5, core_wd3=0xDEADBEEF, plus dbg write to x7 of 0x1234:
  - Core write passes through; dbg_gnt=0.
  - Once core_we=0: dbg_gnt=1 with rf_a3=7, rf_wd3=0x1234 the same cycle.
- core_halt=1, dbg read of x9 after init:
  - rf_a1=9, dbg_gnt=1.
  - Next cycle: dbg_rvalid=1, dbg_rdata=0x20.
- core_we held 1, dbg write pending, MAX_WAIT=8:
  - After 8 blocked cycles, one cycle with core_stall=1, dbg_gnt=1 and the debug data on the write port.
  - Then IDLE with wait_cnt=0.
- Debug write to x0 = 0xFFFF: dbg_gnt=1 and rf_we3=0.
- Core write to x0: rf_we3=0.
- Assert rst at sweep idx=15:
  - All outputs return to reset values immediately.
  - On release, the sweep restarts at idx 0.
